jt900h_ramsrv: RTL and testbench
================================

# jt900h_ramsrv

Memory responder for the JT900H RAM bus: it serves the byte-masked 16-bit accesses issued by the CPU's RAM controller. It holds a word-organised internal RAM with a write-protected low (ROM) region and optional wait-state signalling. It also provides a host programming port for loading ROM/RAM contents. It sits outside the CPU core, on the far side of `ram_addr`/`ram_din`/`ram_we`/`ram_dout`.

## Interface
Parameters:
- `AW`, 12 — word-address bits; capacity 2^AW 16-bit words (8 kB default).
- `WAIT`, 0 — wait states per new read address, 0..3.
- `ROMTOP`, 0 — word indices below this are write-protected from the bus.
- `OPEN`, 16'hFFFF — value returned for out-of-range reads.

Ports:
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `cen`  in  1  — bus clock enable, same signal as the CPU's `cen`.
- `ram_addr`  in  24  — byte address; bit 0 ignored.
- `ram_din`  in  16  — write data; high byte is lane 1.
- `ram_we`  in  2  — byte-lane write mask.
- `ram_dout`  out  16  — read data, registered.
- `ram_wait`  out  1  — high while the current read address is still inside its wait-state window.
- `wr_err`  out  1  — one-`clk` pulse when a bus write is rejected.
- `prog_we`  in  1  — host write strobe.
- `prog_addr`  in  AW  — host word address.
- `prog_data`  in  16  — host write data.
- `prog_mask`  in  2  — host byte-lane mask.

## Operation
- Word index is `ram_addr[AW:1]`. An access is in range when `ram_addr[23:AW+1]==0`.

Reads:
- `ram_dout` is updated every `clk`, not gated by `cen`.
- In range: `ram_dout` = `mem[idx]`. Out of range: `ram_dout` = `OPEN`.

Bus writes:
- Sampled on a `cen` edge when `ram_we!=0`.
- Lanes are written independently: lane 0 ← `ram_din[7:0]`, lane 1 ← `ram_din[15:8]`.
- The write is rejected and `wr_err` pulses when either holds:
  - the access is out of range;
  - `idx < ROMTOP`.
- Memory is not modified by a rejected write.

Host writes:
- On any `clk` with `prog_we` high, `mem[prog_addr]` is written under `prog_mask`.
- Host writes ignore `ROMTOP`.

Collision buffer:
- A bus write that coincides with `prog_we` is captured in a one-entry pending buffer (index, data, mask).
- The pending entry commits on the first `clk` with `prog_we` low, whether or not `cen` is high.
- A new bus write arriving while an entry is pending is dropped and pulses `wr_err`; the pending entry is kept.

Read-during-write ordering:
- Same index: `ram_dout` on the next `clk` shows the merged new data (write-first).

Wait states:
- Counter `wcnt` (2 bits).
- Loaded with `WAIT` on a `cen` edge when `ram_we==0` and the word index differs from the index latched at the previous such edge.
- Decrements on each `cen` while nonzero.
- `ram_wait = (wcnt!=0)`.
- With `WAIT=0`, `ram_wait` stays 0.

Reset:
- `ram_dout`=0, `ram_wait`=0, `wr_err`=0.
- Pending buffer empty, `wcnt`=0, latched index=0.
- Memory contents are not reset.
- Asserting `rst_n` low mid-collision discards the pending write.

## Timing
- Read latency: one `clk` from a stable `ram_addr`. Zero-wait for the initiator whenever `cen` is active at most every other `clk`.
- Write commit: the memory array updates at the `cen` edge sampling `ram_we`; the next `clk` read of that index sees new data.
- Collision: the commit is delayed until the first `clk` with `prog_we`=0. A read of that index before commit returns old data.
- `wr_err`: asserted the `clk` after the offending `cen` edge, for exactly one `clk`.
- `ram_wait`: rises the `clk` after the `cen` edge that changes the index; falls after `WAIT` further `cen` edges.

## Test plan
- Host loads word 0x010 = 0xA55A; bus read at `ram_addr`=0x000020 → `ram_dout`=0xA55A one `clk` later, `ram_wait`=0.
- `ROMTOP`=0x10, bus write `ram_we`=2'b11 at addr 0x000010 → `wr_err` pulse, word unchanged. Write at 0x000020 with `ram_we`=2'b10 → only the high byte changes.
- Bus write coincident with a 3-`clk` `prog_we` burst to a different index → bus data lands one `clk` after `prog_we` falls. A second bus write during the burst → `wr_err`, first write still commits.
- Read at `ram_addr`=0x010000 with `AW`=12 → `ram_dout`=0xFFFF. Write there → `wr_err`.
- `WAIT`=2, `cen` every other `clk`, reads at 0x40 then 0x42 → `ram_wait` high for 2 `cen` periods after each address change. Re-reading 0x41 (same word as 0x40) → no wait.
- `rst_n` pulsed low with an entry pending → pending dropped, all outputs 0, memory otherwise intact.

Source files
------------

// File: rtl/jt900h_ramsrv.sv
// jt900h_ramsrv: RAM-bus responder for the JT900H CPU.
// Word-organised RAM with a write-protected low region, a host programming
// port, a one-entry buffer for bus writes that collide with host writes,
// and optional wait-state signalling on read address changes.
module jt900h_ramsrv #(
  parameter int          AW     = 12,
  parameter int          WAIT   = 0,
  parameter int          ROMTOP = 0,
  parameter logic [15:0] OPEN   = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [23:0]   ram_addr,
  input  logic [15:0]   ram_din,
  input  logic [1:0]    ram_we,
  output logic [15:0]   ram_dout,
  output logic          ram_wait,
  output logic          wr_err,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW:0]   ROMTOP_W = (AW+1)'(ROMTOP);
  localparam logic [1:0]    WAIT_W   = 2'(WAIT);

  logic [15:0]   r_mem [0:DEPTH-1];

  logic          r_pend;
  logic [AW-1:0] r_pend_idx;
  logic [15:0]   r_pend_data;
  logic [1:0]    r_pend_mask;
  logic          r_wr_err;
  logic [1:0]    r_wcnt;
  logic [AW-1:0] r_last_idx;
  logic [15:0]   r_dout;

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_rom;
  logic          w_bus_wr;
  logic          w_bus_bad;
  logic          w_bus_drop;
  logic          w_bus_ok;
  logic          w_bus_cap;
  logic          w_bus_direct;
  logic          w_we;
  logic [AW-1:0] w_widx;
  logic [15:0]   w_wdata;
  logic [1:0]    w_wmask;
  logic [15:0]   w_cur;
  logic [15:0]   w_merge;
  logic          w_unused;

  assign w_unused   = ram_addr[0];
  assign w_idx      = ram_addr[AW:1];
  assign w_in_range = (ram_addr[23:AW+1] == '0);
  assign w_rom      = ({1'b0, w_idx} < ROMTOP_W);

  // Bus write classification: rejected, dropped (buffer busy), buffered or direct
  assign w_bus_wr     = cen && (ram_we != 2'b00);
  assign w_bus_bad    = w_bus_wr && (!w_in_range || w_rom);
  assign w_bus_drop   = w_bus_wr && !w_bus_bad && r_pend;
  assign w_bus_ok     = w_bus_wr && !w_bus_bad && !r_pend;
  assign w_bus_cap    = w_bus_ok && prog_we;
  assign w_bus_direct = w_bus_ok && !prog_we;

  // Single memory write port: host first, then pending commit, then bus
  always_comb begin
    w_we    = 1'b0;
    w_widx  = prog_addr;
    w_wdata = prog_data;
    w_wmask = prog_mask;
    if (prog_we) begin
      w_we = 1'b1;
    end else if (r_pend) begin
      w_we    = 1'b1;
      w_widx  = r_pend_idx;
      w_wdata = r_pend_data;
      w_wmask = r_pend_mask;
    end else if (w_bus_direct) begin
      w_we    = 1'b1;
      w_widx  = w_idx;
      w_wdata = ram_din;
      w_wmask = ram_we;
    end
  end

  // Memory array write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      if (w_wmask[0]) r_mem[w_widx][7:0]  <= w_wdata[7:0];
      if (w_wmask[1]) r_mem[w_widx][15:8] <= w_wdata[15:8];
    end
  end

  // Write-first read data: merge lanes being written this clock into the read word
  always_comb begin
    w_cur   = r_mem[w_idx];
    w_merge = w_cur;
    if (w_we && (w_widx == w_idx)) begin
      if (w_wmask[0]) w_merge[7:0]  = w_wdata[7:0];
      if (w_wmask[1]) w_merge[15:8] = w_wdata[15:8];
    end
  end

  // Read register, collision buffer, error pulse and wait-state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= 16'h0000;
      r_pend      <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_data <= 16'h0000;
      r_pend_mask <= 2'b00;
      r_wr_err    <= 1'b0;
      r_wcnt      <= 2'd0;
      r_last_idx  <= '0;
    end else begin
      r_dout   <= w_in_range ? w_merge : OPEN;
      r_wr_err <= w_bus_bad || w_bus_drop;
      if (w_bus_cap) begin
        r_pend      <= 1'b1;
        r_pend_idx  <= w_idx;
        r_pend_data <= ram_din;
        r_pend_mask <= ram_we;
      end else if (r_pend && !prog_we) begin
        r_pend <= 1'b0;
      end
      if (cen) begin
        if ((ram_we == 2'b00) && (w_idx != r_last_idx)) begin
          r_wcnt     <= WAIT_W;
          r_last_idx <= w_idx;
        end else if (r_wcnt != 2'd0) begin
          r_wcnt <= r_wcnt - 2'd1;
        end
      end
    end
  end

  assign ram_dout = r_dout;
  assign ram_wait = (r_wcnt != 2'd0);
  assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_jt900h_ramsrv.sv
// Scoreboard bench for jt900h_ramsrv (AW=12, WAIT=2, ROMTOP=0x10).
// The driver steps a behavioural model each clk and queues the expected
// outputs; a separate monitor pops and compares after every rising edge.
module tb_jt900h_ramsrv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [23:0] ram_addr = '0;
  logic [15:0] ram_din = '0;
  logic [1:0]  ram_we = '0;
  logic [15:0] ram_dout;
  logic        ram_wait;
  logic        wr_err;
  logic        prog_we = 1'b0;
  logic [11:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [1:0]  prog_mask = '0;

  int n_checks = 0;
  int n_fail   = 0;

  jt900h_ramsrv #(.AW(12), .WAIT(2), .ROMTOP(16), .OPEN(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .ram_wait(ram_wait), .wr_err(wr_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dout;
    logic        wt;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];

  // reference model state
  logic [15:0] m_mem [0:4095];
  logic        m_pend = 1'b0;
  logic [11:0] m_pidx;
  logic [15:0] m_pdata;
  logic [1:0]  m_pmask;
  int          m_wcnt = 0;
  logic [11:0] m_last = '0;
  int          cyc_no = 0;

  task automatic check(string name, logic [15:0] got, logic [15:0] exp, int c);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
    end
  endtask

  task automatic mwrite(logic [11:0] a, logic [15:0] d, logic [1:0] m);
    if (m[0]) m_mem[a][7:0]  = d[7:0];
    if (m[1]) m_mem[a][15:8] = d[15:8];
  endtask

  // One clk of the model using the inputs currently driven
  task automatic step();
    logic inr, err, cap, direct;
    logic [11:0] idx;
    exp_t e;
    inr = (ram_addr[23:13] == 11'd0);
    idx = ram_addr[12:1];
    err = 0; cap = 0; direct = 0;
    if (cen && ram_we != 2'b00) begin
      if (!inr || idx < 16) err = 1;
      else if (m_pend)      err = 1;
      else if (prog_we)     cap = 1;
      else                  direct = 1;
    end
    if (prog_we) mwrite(prog_addr, prog_data, prog_mask);
    else if (m_pend) begin
      mwrite(m_pidx, m_pdata, m_pmask);
      m_pend = 0;
    end else if (direct) mwrite(idx, ram_din, ram_we);
    if (cap) begin
      m_pend = 1; m_pidx = idx; m_pdata = ram_din; m_pmask = ram_we;
    end
    if (cen) begin
      if (ram_we == 2'b00 && idx != m_last) begin
        m_wcnt = 2;
        m_last = idx;
      end else if (m_wcnt > 0) m_wcnt--;
    end
    e.dout = inr ? m_mem[idx] : 16'hFFFF;
    e.wt   = (m_wcnt != 0);
    e.err  = err;
    e.cyc  = cyc_no;
    q.push_back(e);
    cyc_no++;
  endtask

  task automatic cyc(logic c, logic [23:0] a, logic [15:0] d, logic [1:0] we,
                     logic pwe, logic [11:0] pa, logic [15:0] pd, logic [1:0] pm);
    @(negedge clk);
    cen = c; ram_addr = a; ram_din = d; ram_we = we;
    prog_we = pwe; prog_addr = pa; prog_data = pd; prog_mask = pm;
    step();
  endtask

  task automatic rd(logic c, logic [23:0] a);
    cyc(c, a, 16'h0, 2'b00, 1'b0, 12'h0, 16'h0, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cen = 0; ram_we = 0; prog_we = 0;
    #1;
    check("rst_dout", ram_dout, 16'h0, cyc_no);
    check("rst_wait", {15'd0, ram_wait}, 16'h0, cyc_no);
    check("rst_err",  {15'd0, wr_err},   16'h0, cyc_no);
    m_pend = 0; m_wcnt = 0; m_last = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dout", ram_dout, e.dout, e.cyc);
        check("wait", {15'd0, ram_wait}, {15'd0, e.wt}, e.cyc);
        check("wr_err", {15'd0, wr_err}, {15'd0, e.err}, e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int burst;
    logic [23:0] a;
    for (int i = 0; i < 4096; i++) m_mem[i] = 16'h0000;
    do_reset();
    // preload words 0..63 through the host port
    for (int i = 0; i < 64; i++)
      cyc(0, 24'h0, 16'h0, 2'b00, 1, 12'(i), 16'($urandom), 2'b11);
    // host load then bus read
    cyc(0, 24'h0, 16'h0, 2'b00, 1, 12'h010, 16'hA55A, 2'b11);
    rd(1, 24'h000020);
    rd(0, 24'h000020);
    // ROM-region write rejected; high-lane write accepted
    cyc(1, 24'h000010, 16'h1234, 2'b11, 0, 12'h0, 16'h0, 2'b00);
    rd(0, 24'h000010);
    cyc(1, 24'h000020, 16'hBEEF, 2'b10, 0, 12'h0, 16'h0, 2'b00);
    rd(0, 24'h000020);
    // collision with a 3-clk host burst, second bus write dropped
    cyc(1, 24'h000060, 16'h1111, 2'b11, 1, 12'h031, 16'hC001, 2'b11);
    cyc(0, 24'h000060, 16'h0, 2'b00, 1, 12'h032, 16'hC002, 2'b11);
    cyc(1, 24'h000062, 16'h2222, 2'b11, 1, 12'h033, 16'hC003, 2'b11);
    rd(0, 24'h000060);
    rd(0, 24'h000062);
    // out-of-range read and write
    rd(1, 24'h010000);
    cyc(1, 24'h010000, 16'h5555, 2'b11, 0, 12'h0, 16'h0, 2'b00);
    rd(0, 24'h010000);
    // wait states with cen every other clk
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 24'h40 : (k == 1) ? 24'h42 : 24'h41;
      for (int j = 0; j < 4; j++) begin
        rd(1, a);
        rd(0, a);
      end
    end
    // reset with a pending entry
    cyc(1, 24'h000070, 16'h7777, 2'b11, 1, 12'h005, 16'h0505, 2'b11);
    do_reset();
    rd(0, 24'h000070);
    rd(0, 24'h00000A);
    // randomized traffic
    burst = 0;
    a = 24'h0;
    for (int i = 0; i < 3000; i++) begin
      logic c, pwe;
      logic [1:0] we;
      if ($urandom_range(0, 99) >= 40) begin
        if ($urandom_range(0, 99) < 85)
          a = {11'd0, 6'($urandom_range(0, 63)), 1'($urandom)};
        else
          a = 24'($urandom) | (24'd1 << $urandom_range(13, 23));
      end
      c  = 1'($urandom);
      we = ($urandom_range(0, 99) < 30) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (burst == 0 && $urandom_range(0, 99) < 10) burst = $urandom_range(1, 4);
      pwe = (burst > 0);
      if (burst > 0) burst--;
      cyc(c, a, 16'($urandom), we, pwe, 12'($urandom_range(0, 63)),
          16'($urandom), 2'($urandom));
    end
    rd(0, 24'h0);
    repeat (3) @(negedge clk);
    check("queue_drained", 16'(q.size()), 16'h0, cyc_no);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
